// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage feeding decode.
//   Owns the fetch PC and issues in-order word requests to instruction memory.
//   Returned words are paired with their request PC and buffered in a small
//   queue. The decode-facing register (o_*) is refilled once per cycle unless
//   stall is high. A redirect from execute flushes everything and restarts
//   fetch at redirect_pc.
// Ports:
//   clk, rst (async, active-low)
//   stall                        downstream hold of o_valid/o_insn/o_pc
//   redirect, redirect_pc        flush and restart fetch (bits [1:0] ignored)
//   imem_req_valid/ready/addr    request channel (addr = fetch PC)
//   imem_rsp_valid/data          in-order responses, latency >= 1 cycle
//   o_valid, o_insn, o_pc        instruction presented to decode
// Optional build macro FETCH_PERF_EN adds o_perf_fetched, o_perf_dropped and
// o_perf_starved (32-bit wrapping event counters).
module fetch_queue #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        o_valid,
  output logic [31:0] o_insn,
  output logic [31:0] o_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] o_perf_fetched,
  output logic [31:0] o_perf_dropped,
  output logic [31:0] o_perf_starved
`endif
);

  localparam int unsigned QAW = $clog2(QUEUE_DEPTH);
  localparam int unsigned QCW = QAW + 1;
  localparam int unsigned OCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]    fetch_pc;
  logic [OCW-1:0] outstanding;
  logic [OCW-1:0] outstanding_next;
  logic [OCW-1:0] drop_cnt;

  // PC tracking FIFO: one entry per accepted-but-unanswered request
  logic [31:0]    pcf_mem [MAX_OUTSTANDING];
  logic [PAW-1:0] pcf_head;
  logic [PAW-1:0] pcf_tail;

  // instruction queue
  logic [31:0]    q_insn [QUEUE_DEPTH];
  logic [31:0]    q_pc   [QUEUE_DEPTH];
  logic [QAW-1:0] q_head;
  logic [QAW-1:0] q_tail;
  logic [QCW-1:0] q_count;

  logic        credit_ok;
  logic        req_fire;
  logic        rsp_keep;
  logic        q_empty;
  logic        out_pop;
  logic        bypass;
  logic        q_push;
  logic [31:0] rsp_pc;
  logic        unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  function automatic logic [PAW-1:0] pcf_next(input logic [PAW-1:0] p);
    if (MAX_OUTSTANDING == 1) return '0;
    if (p == PAW'(MAX_OUTSTANDING - 1)) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin
    // Credits count in-flight requests as if already queued, so every
    // response always has a free slot (dropped ones are counted too).
    credit_ok = (32'(outstanding) < MAX_OUTSTANDING) &&
                ((32'(outstanding) + 32'(q_count)) < QUEUE_DEPTH);
    imem_req_valid = rst && !redirect && credit_ok;
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_keep       = imem_rsp_valid && (drop_cnt == '0) && !redirect;
    rsp_pc         = pcf_mem[pcf_head];
    q_empty        = (q_count == '0);
    out_pop        = !redirect && !stall && !q_empty;
    bypass         = !redirect && !stall && q_empty && rsp_keep;
    q_push         = rsp_keep && !bypass;
    outstanding_next = outstanding;
    case ({req_fire, imem_rsp_valid})
      2'b10:   outstanding_next = outstanding + 1'b1;
      2'b01:   outstanding_next = outstanding - 1'b1;
      default: outstanding_next = outstanding;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      pcf_head    <= '0;
      pcf_tail    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (req_fire) pcf_tail <= pcf_next(pcf_tail);
      if (imem_rsp_valid) pcf_head <= pcf_next(pcf_head);
      if (redirect) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        // every request still in flight after this cycle belongs to the old path
        drop_cnt <= outstanding_next;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pcf_mem[pcf_tail] <= fetch_pc;
    if (q_push) begin
      q_insn[q_tail] <= imem_rsp_data;
      q_pc[q_tail]   <= rsp_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_head  <= '0;
      q_tail  <= '0;
      q_count <= '0;
    end else if (redirect) begin
      q_head  <= '0;
      q_tail  <= '0;
      q_count <= '0;
    end else begin
      if (q_push) q_tail <= q_tail + 1'b1;
      if (out_pop) q_head <= q_head + 1'b1;
      case ({q_push, out_pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid <= 1'b0;
      o_insn  <= NOP;
      o_pc    <= '0;
    end else if (redirect) begin
      o_valid <= 1'b0;
      o_insn  <= NOP;
    end else if (!stall) begin
      if (out_pop) begin
        o_valid <= 1'b1;
        o_insn  <= q_insn[q_head];
        o_pc    <= q_pc[q_head];
      end else if (bypass) begin
        o_valid <= 1'b1;
        o_insn  <= imem_rsp_data;
        o_pc    <= rsp_pc;
      end else begin
        o_valid <= 1'b0;
        o_insn  <= NOP;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_perf_fetched <= '0;
      o_perf_dropped <= '0;
      o_perf_starved <= '0;
    end else begin
      if (o_valid && !stall) o_perf_fetched <= o_perf_fetched + 32'd1;
      if (imem_rsp_valid && (redirect || (drop_cnt != '0)))
        o_perf_dropped <= o_perf_dropped + 32'd1;
      if (!stall && !o_valid && !redirect) o_perf_starved <= o_perf_starved + 32'd1;
    end
  end
`endif

endmodule
